// File: rtl/alsu_seq.sv
// Sequential ALSU: valid/ready bundle capture, single-cycle logic/add/shift ops,
// iterative shift-add multiply, and an error LED blinker.
module alsu_seq #(
   parameter int    WIDTH          = 4,
   parameter string INPUT_PRIORITY = "A",
   parameter string FULL_ADDER     = "ON",
   parameter int    LED_W          = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   input  logic [2:0]           opcode,
   input  logic                 cin,
   input  logic                 serial_in,
   input  logic                 direction,
   input  logic                 red_op_A,
   input  logic                 red_op_B,
   input  logic                 bypass_A,
   input  logic                 bypass_B,
   output logic [2*WIDTH-1:0]   out,
   output logic                 out_valid,
   output logic                 err,
   output logic [LED_W-1:0]     leds
);

   localparam int OW      = 2 * WIDTH;
   localparam int CW      = $clog2(WIDTH);
   localparam bit PRI_A   = (INPUT_PRIORITY == "A");
   localparam bit PRI_B   = (INPUT_PRIORITY == "B");
   localparam bit ADD_CIN = (FULL_ADDER == "ON");
   localparam bit ADD_NC  = (FULL_ADDER == "OFF");

   typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

   state_t           state_r, state_n;
   logic [WIDTH-1:0] a_r, b_r;
   logic [2:0]       op_r;
   logic             cin_r, si_r, dir_r, ra_r, rb_r, ba_r, bb_r;
   logic [OW-1:0]    acc_r;
   logic [CW-1:0]    cnt_r;

   logic             invalid_s, bypass_s, mul_go_s, last_s, err_n_s;
   logic [WIDTH-1:0] pri_op_s, red_src_s;
   logic [OW-1:0]    result_s, b_ext_s, partial_s, sum_s;

   assign in_ready  = (state_r == IDLE);
   assign bypass_s  = ba_r | bb_r;
   assign invalid_s = (op_r == 3'd6) || (op_r == 3'd7) ||
                      ((ra_r | rb_r) && (op_r[2:1] != 2'b00));
   assign mul_go_s  = (op_r == 3'd3) && !bypass_s && !invalid_s;
   assign pri_op_s  = PRI_A ? a_r : (PRI_B ? b_r : {WIDTH{1'b0}});
   assign last_s    = (cnt_r == CW'(WIDTH - 1));
   assign b_ext_s   = {{WIDTH{1'b0}}, b_r};
   assign partial_s = a_r[cnt_r] ? (b_ext_s << cnt_r) : {OW{1'b0}};
   assign sum_s     = acc_r + partial_s;

   // Single-cycle result for the captured bundle, bypass first, then invalid, then opcode.
   always_comb begin
      result_s  = {OW{1'b0}};
      red_src_s = b_r;
      if (ra_r && rb_r) begin
         red_src_s = pri_op_s;
      end else if (ra_r) begin
         red_src_s = a_r;
      end else begin
         red_src_s = b_r;
      end
      if (ba_r && bb_r) begin
         result_s = {{WIDTH{1'b0}}, pri_op_s};
      end else if (ba_r) begin
         result_s = {{WIDTH{1'b0}}, a_r};
      end else if (bb_r) begin
         result_s = {{WIDTH{1'b0}}, b_r};
      end else if (invalid_s) begin
         result_s = {OW{1'b0}};
      end else begin
         case (op_r)
            3'd0: begin
               if (ra_r | rb_r) result_s = {{(OW-1){1'b0}}, &red_src_s};
               else             result_s = {{WIDTH{1'b0}}, a_r & b_r};
            end
            3'd1: begin
               if (ra_r | rb_r) result_s = {{(OW-1){1'b0}}, ^red_src_s};
               else             result_s = {{WIDTH{1'b0}}, a_r ^ b_r};
            end
            3'd2: begin
               if (ADD_CIN)     result_s = OW'(a_r) + OW'(b_r) + OW'(cin_r);
               else if (ADD_NC) result_s = OW'(a_r) + OW'(b_r);
               else             result_s = {OW{1'b0}};
            end
            3'd4: begin
               if (dir_r) result_s = {out[OW-2:0], si_r};
               else       result_s = {si_r, out[OW-1:1]};
            end
            3'd5: begin
               if (dir_r) result_s = {out[OW-2:0], out[OW-1]};
               else       result_s = {out[0], out[OW-1:1]};
            end
            default: result_s = {OW{1'b0}};
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= IDLE;
      else     state_r <= state_n;
   end

   // Next-state decode.
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) state_n = EXEC;
            else          state_n = IDLE;
         end
         EXEC: begin
            if (mul_go_s) state_n = MUL;
            else          state_n = IDLE;
         end
         MUL: begin
            if (last_s) state_n = IDLE;
            else        state_n = MUL;
         end
         default: state_n = IDLE;
      endcase
   end

   // Error flag follows whichever bundle completes; MUL bundles are always valid.
   always_comb begin
      err_n_s = err;
      if (state_r == EXEC && !mul_go_s) begin
         err_n_s = invalid_s && !bypass_s;
      end else if (state_r == MUL && last_s) begin
         err_n_s = 1'b0;
      end else begin
         err_n_s = err;
      end
   end

   // Operand capture, execution, multiply iteration and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_r       <= {WIDTH{1'b0}};
         b_r       <= {WIDTH{1'b0}};
         op_r      <= 3'd0;
         cin_r     <= 1'b0;
         si_r      <= 1'b0;
         dir_r     <= 1'b0;
         ra_r      <= 1'b0;
         rb_r      <= 1'b0;
         ba_r      <= 1'b0;
         bb_r      <= 1'b0;
         acc_r     <= {OW{1'b0}};
         cnt_r     <= {CW{1'b0}};
         out       <= {OW{1'b0}};
         out_valid <= 1'b0;
         err       <= 1'b0;
         leds      <= {LED_W{1'b0}};
      end else begin
         out_valid <= 1'b0;
         err       <= err_n_s;
         // Blink only once err has been high for at least one edge.
         leds      <= (err && err_n_s) ? ~leds : {LED_W{1'b0}};
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= A;
                  b_r   <= B;
                  op_r  <= opcode;
                  cin_r <= cin;
                  si_r  <= serial_in;
                  dir_r <= direction;
                  ra_r  <= red_op_A;
                  rb_r  <= red_op_B;
                  ba_r  <= bypass_A;
                  bb_r  <= bypass_B;
               end
            end
            EXEC: begin
               if (mul_go_s) begin
                  acc_r <= {OW{1'b0}};
                  cnt_r <= {CW{1'b0}};
               end else begin
                  out       <= result_s;
                  out_valid <= 1'b1;
               end
            end
            MUL: begin
               acc_r <= sum_s;
               cnt_r <= cnt_r + CW'(1);
               if (last_s) begin
                  out       <= sum_s;
                  out_valid <= 1'b1;
               end
            end
            default: begin
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alsu_seq.sv
// Randomised self-checking bench for alsu_seq (WIDTH=4), two instances differing in INPUT_PRIORITY.
module tb_alsu_seq;

   localparam int W  = 4;
   localparam int OW = 8;
   localparam int LW = 16;

   logic          clk = 1'b0;
   logic          rst, in_valid, cin, serial_in, direction;
   logic          red_op_A, red_op_B, bypass_A, bypass_B;
   logic [W-1:0]  A, B;
   logic [2:0]    opcode;
   logic          in_ready, out_valid, err;
   logic [OW-1:0] out;
   logic [LW-1:0] leds;
   logic          in_ready_b, out_valid_b, err_b;
   logic [OW-1:0] out_b;
   logic [LW-1:0] leds_b;

   int            checks = 0, failures = 0, cyc = 0, rise_cyc = 0;
   logic [OW-1:0] m_out = 8'h00, m_out_b = 8'h00;
   bit            m_err = 1'b0;

   always #5 clk = ~clk;

   alsu_seq #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
      .opcode(opcode), .cin(cin), .serial_in(serial_in), .direction(direction),
      .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
      .out(out), .out_valid(out_valid), .err(err), .leds(leds));

   alsu_seq #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("ON"), .LED_W(LW)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .A(A), .B(B),
      .opcode(opcode), .cin(cin), .serial_in(serial_in), .direction(direction),
      .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
      .out(out_b), .out_valid(out_valid_b), .err(err_b), .leds(leds_b));

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   // LEDs: zero while err is low; after err rises, all-ones on odd edges since the rise.
   function automatic logic [LW-1:0] exp_leds();
      if (!m_err) return 16'h0000;
      return (((cyc - rise_cyc) % 2) == 1) ? 16'hFFFF : 16'h0000;
   endfunction

   function automatic logic [OW-1:0] model(input logic [OW-1:0] cur, input byte pri,
                                           input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input bit ci, input bit si,
                                           input bit dir, input bit ra, input bit rb,
                                           input bit ba, input bit bb);
      int c, ai, bi, sel, val;
      c = cur; ai = a; bi = b; val = 0;
      if (ba && bb) return (pri == "A") ? OW'(ai) : ((pri == "B") ? OW'(bi) : 8'h00);
      if (ba) return OW'(ai);
      if (bb) return OW'(bi);
      if (op >= 3'd6 || ((ra || rb) && op >= 3'd2)) return 8'h00;
      if (ra && rb) sel = (pri == "A") ? ai : bi;
      else if (ra)  sel = ai;
      else          sel = bi;
      case (op)
         3'd0: val = (ra || rb) ? ((sel == 15) ? 1 : 0) : (ai & bi);
         3'd1: val = (ra || rb) ? ($countones(sel) % 2) : (ai ^ bi);
         3'd2: val = ai + bi + int'(ci);
         3'd3: val = ai * bi;
         3'd4: val = dir ? (c * 2 + int'(si)) : (int'(si) * 128 + c / 2);
         3'd5: val = dir ? (c * 2 + c / 128) : ((c % 2) * 128 + c / 2);
         default: val = 0;
      endcase
      return val[7:0];
   endfunction

   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                         input bit ci, input bit si, input bit dir, input bit ra, input bit rb,
                         input bit ba, input bit bb, input int idle);
      logic [OW-1:0] e, eb;
      int lat, cnt;
      bit inv, e_err;
      repeat (idle) begin
         tick();
         check_val("idle_valid", out_valid, 1'b0);
         check_val("idle_leds", leds, exp_leds());
      end
      check_val("ready_idle", in_ready, 1'b1);
      A = a; B = b; opcode = op; cin = ci; serial_in = si; direction = dir;
      red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb; in_valid = 1'b1;
      e     = model(m_out, "A", a, b, op, ci, si, dir, ra, rb, ba, bb);
      eb    = model(m_out_b, "B", a, b, op, ci, si, dir, ra, rb, ba, bb);
      inv   = (op >= 3'd6) || ((ra || rb) && op >= 3'd2);
      e_err = inv && !(ba || bb);
      lat   = (op == 3'd3 && !(ba || bb) && !inv) ? W + 1 : 1;
      tick();
      // Garbage on the inputs while busy must be ignored.
      in_valid = 1'($urandom); A = 4'($urandom); B = 4'($urandom); opcode = 3'($urandom);
      bypass_A = 1'($urandom); red_op_B = 1'($urandom);
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 3 * W) begin
         check_val("busy_ready", in_ready, 1'b0);
         check_val("busy_hold", out, m_out);
         check_val("busy_leds", leds, exp_leds());
         tick();
         cnt++;
      end
      check_val("latency", cnt, lat);
      check_val("out", out, e);
      check_val("out_prioB", out_b, eb);
      m_out = e; m_out_b = eb;
      if (e_err && !m_err) rise_cyc = cyc;
      m_err = e_err;
      check_val("err", err, m_err);
      check_val("ready_after", in_ready, 1'b1);
      check_val("leds_done", leds, exp_leds());
      in_valid = 1'b0;
      tick();
      check_val("valid_pulse", out_valid, 1'b0);
      check_val("leds_post", leds, exp_leds());
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; A = 4'h0; B = 4'h0; opcode = 3'd0; cin = 1'b0;
      serial_in = 1'b0; direction = 1'b0; red_op_A = 1'b0; red_op_B = 1'b0;
      bypass_A = 1'b0; bypass_B = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check_val("rst_out", out, 8'h00);
      check_val("rst_valid", out_valid, 1'b0);
      check_val("rst_err", err, 1'b0);
      check_val("rst_leds", leds, 16'h0000);
      check_val("rst_ready", in_ready, 1'b1);

      //          a      b      op    ci    si    dir   ra    rb    ba    bb    idle
      run_op(4'hF, 4'hF, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("add_1F", out, 8'h1F);
      run_op(4'hF, 4'hD, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      check_val("mul_C3", out, 8'hC3);
      run_op(4'h0, 4'hF, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("mul_zero", out, 8'h00);
      run_op(4'h3, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      run_op(4'h0, 4'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("rot_81", out, 8'h81);
      run_op(4'h0, 4'h0, 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("shl_02", out, 8'h02);
      run_op(4'h3, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      run_op(4'h0, 4'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_op(4'h0, 4'h0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("ror_C0", out, 8'hC0);
      run_op(4'h0, 4'h0, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("shr_E0", out, 8'hE0);
      run_op(4'h5, 4'h9, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("inv_err", err, 1'b1);
      tick(); check_val("blink_1", leds, 16'h0000);
      tick(); check_val("blink_2", leds, 16'hFFFF);
      run_op(4'h7, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
      check_val("xor_red", out, 8'h01);
      check_val("xor_err", err, 1'b0);
      run_op(4'hA, 4'h3, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
      check_val("byp_inv", out, 8'h0A);
      run_op(4'h5, 4'h9, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
      check_val("byp_priA", out, 8'h05);
      check_val("byp_priB", out_b, 8'h09);
      run_op(4'hF, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      check_val("and_red", out, 8'h01);

      // Reset abandons an in-flight multiply on its second iteration.
      run_op(4'h1, 4'h2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      run_op(4'h9, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
      run_op(4'h1, 4'h2, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      A = 4'hF; B = 4'hF; opcode = 3'd3; bypass_A = 1'b0; bypass_B = 1'b0;
      red_op_A = 1'b0; red_op_B = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_out = 8'h00; m_out_b = 8'h00; m_err = 1'b0;
      check_val("mrst_out", out, 8'h00);
      check_val("mrst_leds", leds, 16'h0000);
      check_val("mrst_err", err, 1'b0);
      check_val("mrst_ready", in_ready, 1'b1);
      check_val("mrst_valid", out_valid, 1'b0);
      run_op(4'h3, 4'h4, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      check_val("post_rst_add", out, 8'h07);

      for (int i = 0; i < 200; i++) begin
         run_op(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alsu_seq.md
Name: alsu_seq

Overview:
- Parametrised next-generation ALSU: generic operand width, valid/ready input handshake, one-cycle result valid pulse.
- Multiply is an iterative shift-add sequence over WIDTH cycles instead of an instantiated multiplier IP.
- Keeps the AND/XOR/ADD/MUL/SHIFT/ROTATE opcode set, bypass, reduction and invalid-LED blink behaviour.
- Sits between the operand source and the display/LED logic of the ALU datapath.

Parameters:
- WIDTH, 4: operand width in bits (>=2). Result width is 2*WIDTH.
- INPUT_PRIORITY, "A": operand selected when both bypass flags or both reduction flags are set. "A" or "B"; any other value selects 0.
- FULL_ADDER, "ON": "ON" means ADD = A+B+cin. "OFF" means ADD = A+B. Any other value makes ADD return 0.
- LED_W, 16: LED bus width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle. High only in IDLE.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- opcode  in  3  0=AND, 1=XOR, 2=ADD, 3=MUL, 4=SHIFT, 5=ROTATE, 6/7=invalid.
- cin  in  1  carry-in for ADD.
- serial_in  in  1  shift-in bit for SHIFT.
- direction  in  1  1 = left, 0 = right.
- red_op_A  in  1  reduction on A.
- red_op_B  in  1  reduction on B.
- bypass_A  in  1  pass A through.
- bypass_B  in  1  pass B through.
- out  out  2*WIDTH  result register; holds its value between operations.
- out_valid  out  1  one-cycle pulse when out is updated.
- err  out  1  last accepted bundle was invalid.
- leds  out  LED_W  blink pattern.

Behaviour:
- Reset (synchronous, rst=1 at an edge): out, leds and err go to 0, out_valid goes to 0, state goes to IDLE, iteration counter and accumulator clear, in_ready=1. Reset takes priority over every other event, including an in-flight MUL, which is abandoned with no out_valid.
- FSM states: IDLE, EXEC, MUL.
- IDLE: in_ready=1. On in_valid=1 at edge k, all inputs are captured into internal registers and the state moves to EXEC. If in_valid=0 the state stays IDLE.
- EXEC (edge k+1):
  - If the captured opcode is 3 and the bundle is not bypass/invalid: clear the accumulator, counter=0, go to MUL.
  - Otherwise: write out, pulse out_valid during the following cycle, return to IDLE.
  - Non-MUL latency: accepted at edge k, out updated at edge k+1. Maximum throughput is one bundle per 2 cycles.
- MUL: each cycle, if A[counter]=1 add (B << counter) to the 2*WIDTH accumulator; counter increments. After WIDTH iterations, write the final product to out at edge k+WIDTH+1, pulse out_valid, and return to IDLE.
- in_ready=0 in EXEC and MUL. in_valid is ignored there and no bundle is lost-tracked: the source must hold its bundle until in_ready is high.
- Result priority, first match wins:
  - bypass_A & bypass_B: INPUT_PRIORITY operand, zero-extended.
  - bypass_A alone: A, zero-extended.
  - bypass_B alone: B, zero-extended.
  - invalid: out=0.
  - otherwise: the opcode result.
- Invalid bundle = (opcode==6 or opcode==7) or ((red_op_A|red_op_B) and opcode[2:1]!=0). Bypass overrides invalid.
- AND / XOR: if any reduction flag is set, the result is the 1-bit reduction of the selected operand, zero-extended. When both flags are set, INPUT_PRIORITY picks the operand. With no reduction flag, the result is the bitwise A op B, zero-extended.
- ADD: (WIDTH+1)-bit sum, zero-extended.
- SHIFT operates on the current out value:
  - left: {out[2W-2:0], serial_in}
  - right: {serial_in, out[2W-1:1]}
- ROTATE operates on the current out value:
  - left: {out[2W-2:0], out[2W-1]}
  - right: {out[0], out[2W-1:1]}
- err: set to 1 when an invalid non-bypass bundle completes EXEC. Cleared to 0 when any valid or bypass bundle completes.
- leds: while err=1, invert every clock, starting with all-ones on the edge after err rises. While err=0, leds hold 0.
- No other state changes out. out_valid is never high for two consecutive cycles.

Test Plan (WIDTH=4):
- Reset, then ADD with A=4'hF, B=4'hF, cin=1 accepted at edge k -> out=8'h1F at edge k+1, single out_valid pulse, in_ready low for exactly 1 cycle.
- MUL with A=4'hF, B=4'hD -> in_ready low for 5 cycles, out=8'hC3 at edge k+5, no out_valid before then. Also A=0, B=4'hF -> out=8'h00 at the same latency.
- With out=8'h81: SHIFT left with serial_in=0 -> 8'h02. Then ROTATE right from 8'h81 -> 8'hC0. Then SHIFT right with serial_in=1 from 8'hC0 -> 8'hE0.
- Invalid opcode 6 -> out=0, err=1, leds sequence 16'hFFFF, 16'h0000, 16'hFFFF on successive cycles. Next an XOR with red_op_A=1, A=4'b0111 -> out=8'h01, err=0, leds=0. An invalid bundle with bypass_A=1 -> out=A and err stays 0.
- bypass_A=bypass_B=1, A=5, B=9, INPUT_PRIORITY="A" -> out=8'h05. With INPUT_PRIORITY="B" -> out=8'h09. AND with red_op_A=red_op_B=1, A=4'hF, B=0 -> 8'h01.
- rst asserted on the 2nd MUL iteration -> next cycle out=0, leds=0, err=0, in_ready=1, no out_valid. A new bundle is accepted on the following edge.
